// File: rtl/paddle_pos_ctrl.sv
// paddle_pos_ctrl: arbitrates paddle position updates into clamped shadows and
// commits them to the renderer buses only at frame start, so paddles never tear.
module paddle_pos_ctrl #(
    parameter logic [15:0] X_MAX    = 16'd538,
    parameter logic [15:0] Y_MAX    = 16'd404,
    parameter logic [15:0] P1_X_RST = 16'd0,
    parameter logic [15:0] P2_X_RST = 16'd538,
    parameter logic [15:0] Y_RST    = 16'd202
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        freeze,
    input  logic        p1_valid,
    input  logic [15:0] p1_x,
    input  logic [15:0] p1_y,
    output logic        p1_ready,
    input  logic        p2_valid,
    input  logic [15:0] p2_x,
    input  logic [15:0] p2_y,
    output logic        p2_ready,
    output logic [15:0] p1_x_loc,
    output logic [15:0] p1_y_loc,
    output logic [15:0] p2_x_loc,
    output logic [15:0] p2_y_loc,
    output logic        p1_dirty,
    output logic        p2_dirty,
    output logic        commit_pulse
);
    typedef enum logic {RUN, COMMIT} state_t;

    state_t      state;
    logic        last_p2;
    logic [15:0] p1_sx, p1_sy, p2_sx, p2_sy;

    function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] mx);
        return v[15] ? 16'd0 : (v > mx ? mx : v);
    endfunction

    // On a tie the requester that did not win last time is served.
    assign p1_ready = (state == RUN) && p1_valid && (!p2_valid || last_p2);
    assign p2_ready = (state == RUN) && p2_valid && (!p1_valid || !last_p2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            last_p2      <= 1'b1;
            p1_x_loc     <= P1_X_RST;
            p1_y_loc     <= Y_RST;
            p2_x_loc     <= P2_X_RST;
            p2_y_loc     <= Y_RST;
            p1_sx        <= P1_X_RST;
            p1_sy        <= Y_RST;
            p2_sx        <= P2_X_RST;
            p2_sy        <= Y_RST;
            p1_dirty     <= 1'b0;
            p2_dirty     <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            if (state == RUN) begin
                if (p1_ready) begin
                    p1_sx    <= clamp(p1_x, X_MAX);
                    p1_sy    <= clamp(p1_y, Y_MAX);
                    p1_dirty <= 1'b1;
                    last_p2  <= 1'b0;
                end else if (p2_ready) begin
                    p2_sx    <= clamp(p2_x, X_MAX);
                    p2_sy    <= clamp(p2_y, Y_MAX);
                    p2_dirty <= 1'b1;
                    last_p2  <= 1'b1;
                end
                if (frame_start && !freeze)
                    state <= COMMIT;
            end else begin
                if (p1_dirty) begin
                    p1_x_loc <= p1_sx;
                    p1_y_loc <= p1_sy;
                end
                if (p2_dirty) begin
                    p2_x_loc <= p2_sx;
                    p2_y_loc <= p2_sy;
                end
                p1_dirty     <= 1'b0;
                p2_dirty     <= 1'b0;
                commit_pulse <= 1'b1;
                state        <= RUN;
            end
        end
    end
endmodule
